// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx : LSB-first UART serialiser, start/stop framing, fixed bit period |
// | Optional even-parity bit when UART_TX_PARITY_EN is defined. Rev 1.0       |
// +--------------------------------------------------------------------------+
module uart_tx #(
  parameter int BIT_PERIOD = 10,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int CW = $clog2(DATA_BITS) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t               state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [CW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 serial_n, busy_n, done_n;
  logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity, parity_n;
`endif

  assign bit_tick = (timer == TIMER_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      serial_out <= serial_n;
      tx_busy    <= busy_n;
      tx_done    <= done_n;
`ifdef UART_TX_PARITY_EN
      parity     <= parity_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = bit_tick ? '0 : timer + 1'b1;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    serial_n  = serial_out;
    busy_n    = tx_busy;
    done_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_n  = parity;
`endif

    case (state)
      IDLE: begin
        // Outputs are registered, so the start bit is launched on the accept edge.
        timer_n  = '0;
        serial_n = 1'b1;
        busy_n   = 1'b0;
        if (tx_start) begin
          shift_n  = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_n = ^tx_data;
`endif
          state_n  = START;
          busy_n   = 1'b1;
          serial_n = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_n  = DATA;
          serial_n = shift[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_n = {1'b0, shift[DATA_BITS-1:1]};
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n   = PARITY;
            serial_n  = parity;
`else
            state_n   = STOP;
            serial_n  = 1'b1;
`endif
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            serial_n  = shift_n[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_n  = STOP;
          serial_n = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          state_n  = IDLE;
          serial_n = 1'b1;
          busy_n   = 1'b0;
          done_n   = 1'b1;
        end
      end
      default: begin
        state_n   = IDLE;
        timer_n   = '0;
        bit_cnt_n = '0;
        serial_n  = 1'b1;
        busy_n    = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx : self-checking bench for uart_tx against a bit-level model    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_uart_tx;

  localparam int BP = 10;
  localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = DB + 3;
`else
  localparam int NBITS = DB + 2;
`endif
  localparam int FRAME = NBITS * BP;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          tx_start = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          serial_out, tx_busy, tx_done;

  int total = 0;
  int bad   = 0;

  uart_tx #(.BIT_PERIOD(BP), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .serial_out (serial_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Line level k cycles after the accept edge: frame bit index = k / BP.
  function automatic logic exp_line(input logic [DB-1:0] d, input int k);
    int b;
    b = k / BP;
    if (b == 0) return 1'b0;
    if (b <= DB) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == DB + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic launch(input logic [DB-1:0] d);
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = d;
  endtask

  // Checks every cycle of a frame (plus its tx_done cycle) after the accept edge.
  task automatic check_frame(input logic [DB-1:0] d, input string name, input int poke_k,
                             input logic poke_start, input logic [DB-1:0] poke_data,
                             input bit poke_pulse);
    logic es, eb, ed;
    for (int k = 0; k <= FRAME; k++) begin
      @(negedge clk);
      es = (k == FRAME) ? 1'b1 : exp_line(d, k);
      eb = (k < FRAME);
      ed = (k == FRAME);
      total++;
      if ({serial_out, tx_busy, tx_done} !== {es, eb, ed}) begin
        bad++;
        if (bad <= 40)
          $display("FAIL %s k=%0d got line/busy/done=%b%b%b expected %b%b%b",
                   name, k, serial_out, tx_busy, tx_done, es, eb, ed);
      end
      if (k == poke_k) begin
        tx_start = poke_start;
        tx_data  = poke_data;
      end else if (poke_pulse && k == poke_k + 1) begin
        tx_start = 1'b0;
      end
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      total++;
      if ({serial_out, tx_busy, tx_done} !== 3'b100) begin
        bad++;
        if (bad <= 40)
          $display("FAIL %s cycle=%0d got line/busy/done=%b%b%b expected 100",
                   name, i, serial_out, tx_busy, tx_done);
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    check_idle("reset_held", 3);
    n_rst = 1'b1;
    check_idle("reset_idle", 20);
  endtask

  task automatic test_single();
    launch(8'hA5);
    check_frame(8'hA5, "single_a5", 0, 1'b0, '0, 1'b0);
    check_idle("single_after", 3);
  endtask

  task automatic test_back_to_back();
    launch(8'h3C);
    check_frame(8'h3C, "b2b_3c", 50, 1'b1, 8'hFF, 1'b0);
    check_frame(8'hFF, "b2b_ff", 0, 1'b0, '0, 1'b0);
    check_idle("b2b_after", 3);
  endtask

  task automatic test_busy_ignore();
    launch(8'h00);
    check_frame(8'h00, "busy_00", 35, 1'b1, 8'hFF, 1'b1);
    check_idle("busy_after", 12);
  endtask

  task automatic test_reset_midframe();
    logic [DB-1:0] d;
    d = DB'($urandom);
    launch(d);
    for (int k = 0; k <= 42; k++) begin
      @(negedge clk);
      tx_start = 1'b0;
    end
    #1 n_rst = 1'b0;
    #1;
    total++;
    if ({serial_out, tx_busy, tx_done} !== 3'b100) begin
      bad++;
      $display("FAIL async_reset got line/busy/done=%b%b%b expected 100",
               serial_out, tx_busy, tx_done);
    end
    @(negedge clk);
    n_rst = 1'b1;
    check_idle("post_reset", 2);
    launch(8'h81);
    check_frame(8'h81, "post_reset_81", 0, 1'b0, '0, 1'b0);
    check_idle("post_reset_after", 2);
  endtask

  task automatic test_random();
    logic [DB-1:0] d;
    int            pk;
    for (int n = 0; n < 8; n++) begin
      d  = DB'($urandom);
      pk = $urandom_range(FRAME - 3, 1);
      launch(d);
      check_frame(d, "random", 0, 1'b0, d, 1'b0);
      check_idle("random_gap", $urandom_range(3, 1));
      // Same data again with a spurious busy-time request carrying other data.
      launch(d);
      check_frame(d, "random_poke", pk, 1'b1, ~d, 1'b1);
      check_idle("random_poke_after", 2);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    launch(8'hA5);
    check_frame(8'hA5, "parity_a5", 0, 1'b0, '0, 1'b0);
    check_idle("parity_gap", 2);
    launch(8'h07);
    check_frame(8'h07, "parity_07", 0, 1'b0, '0, 1'b0);
    check_idle("parity_after", 2);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmitter for the UART link. It loads one parallel byte, serialises it LSB-first with a start bit and a stop bit, and drives the line at a fixed bit period counted in clk cycles. It sits opposite the receiver datapath and control unit on the same link and uses the same framing. Bit period and data width must therefore match the receiver side.

Parameters:
BIT_PERIOD, 10, clk cycles per serial bit (legal range >= 2)
DATA_BITS, 8, payload bits per frame (legal range 5..8)

Ports:
clk  input  1  system clock, all state updates on rising edge
n_rst  input  1  asynchronous active-low reset
tx_start  input  1  request to send; sampled only in IDLE
tx_data  input  DATA_BITS  payload; captured on the edge that accepts tx_start
serial_out  output  1  serial line; idle/mark level is 1
tx_busy  output  1  high while a frame is in flight
tx_done  output  1  single-cycle pulse when a frame completes

Behaviour:
- Reset: n_rst is asynchronous, active-low; clock is clk.
  - Reset values: state=IDLE, serial_out=1, tx_busy=0, tx_done=0, counters=0, shift register=0.
  - Reset mid-frame aborts immediately; serial_out returns to 1 without waiting for a clock edge.
- All outputs are registered; no combinational path from inputs to outputs.
- Timer: counts 0..BIT_PERIOD-1, width $clog2(BIT_PERIOD). bit_tick asserts on terminal count; the timer wraps to 0 on the same edge. The timer is held at 0 in IDLE.
- Bit counter: counts 0..DATA_BITS-1, width $clog2(DATA_BITS)+1.
- States:
  - IDLE: serial_out=1, tx_busy=0. If tx_start=1 at an edge: capture tx_data into the shift register, go to START, set tx_busy=1 and serial_out=0 on that same edge.
  - START: hold serial_out=0 for BIT_PERIOD cycles. On bit_tick: go to DATA and drive shift[0].
  - DATA: hold the current bit for BIT_PERIOD cycles. On bit_tick: shift right and increment the bit counter. After bit DATA_BITS-1 completes, go to STOP (or PARITY, see Optional Feature) and clear the bit counter.
  - STOP: serial_out=1 for BIT_PERIOD cycles. On bit_tick: go to IDLE, tx_busy=0, tx_done=1 for exactly one cycle.
- Latency: serial_out falls on the edge that accepts tx_start. The frame occupies (DATA_BITS+2)*BIT_PERIOD cycles. tx_done is high during the cycle following the last stop-bit cycle.
- Busy handling: tx_start while tx_busy=1 is ignored; no queuing. tx_data changes while busy have no effect.
- Back-to-back: tx_start high in the tx_done cycle is accepted, since the state is already IDLE. The next start bit then follows the stop bit with no extra idle cycles.
- tx_start held high continuously sends frames back to back, with tx_data resampled at each accept.
- No undefined states: any illegal encoding recovers to IDLE with serial_out=1.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the captured payload, computed at capture time) for BIT_PERIOD cycles. Frame length becomes (DATA_BITS+3)*BIT_PERIOD.
- Undefined: there is no PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
1. Reset, then idle 20 cycles -> serial_out=1, tx_busy=0, tx_done=0 throughout.
2. BIT_PERIOD=10. Pulse tx_start with tx_data=8'hA5 -> serial_out sequence 0,1,0,1,0,0,1,0,1,1, each held exactly 10 cycles. tx_busy high for 100 cycles. tx_done pulses once at cycle 100 after accept.
3. Send 8'h3C and hold tx_start=1, changing tx_data to 8'hFF at cycle 50 -> first frame still carries 3C. Second frame (FF) starts on the tx_done cycle with no idle bit between frames.
4. Mid-frame (cycle 35 of 8'h00), pulse tx_start with tx_data=8'hFF -> ignored; frame completes as all-zero data; only one tx_done pulse.
5. Assert n_rst low at cycle 42 of a frame -> serial_out=1 and tx_busy=0 before the next clk edge. After release, a new tx_start of 8'h81 produces a clean full frame.
6. With UART_TX_PARITY_EN: send 8'hA5 -> parity bit 0. Send 8'h07 -> parity bit 1. Frame length is 110 cycles.
